counter_b4_ctrl: RTL and testbench
==================================

COUNTER_B4_CTRL -- requirements
Module: counter_b4_ctrl

Interface
REQ-001 Parameter DW, default 4, SHALL be the width of the data loaded into the counter (cmdN_d, b4_D).
REQ-002 Parameter LW, default 4, SHALL be the width of the run-length fields (cmdN_len).
REQ-003 b4_clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 b4_reset_n  in  1  reset, asynchronous and active-low.
REQ-005 req0, req1  in  1  requester N wants a counter operation; held high until ackN.
REQ-006 cmd0_mode, cmd1_mode  in  2  mode for the counter (00, 01, 10, 11).
REQ-007 cmd0_len, cmd1_len  in  LW  run length; enabled cycles = len+1.
REQ-008 cmd0_d, cmd1_d  in  DW  parallel-load value for the counter.
REQ-009 b4_rco  in  1  ripple-carry out returned by the counter.
REQ-010 ack0, ack1  out  1  one-cycle accept pulse to requester N.
REQ-011 b4_enable  out  1  counter enable.
REQ-012 b4_mode  out  2  counter mode.
REQ-013 b4_D  out  DW  counter parallel-load data.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 done_id  out  1  requester that owned the completed operation; valid while done=1.
REQ-017 done_abort  out  1  completion was caused by b4_rco; valid while done=1.

Function
REQ-018 The block SHALL implement the FSM IDLE -> GRANT -> RUN -> DONE -> IDLE, and all outputs SHALL be registered.
REQ-019 IDLE: if any reqN=1, the FSM SHALL go to GRANT and latch the winner's mode, len and d; if no request is pending it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin: with both requests high, the requester not granted last wins; the last-grant register SHALL reset to 1, so req0 wins the first tie.
REQ-021 GRANT SHALL last exactly one cycle with ackN=1 for the winner only; the remaining-cycle counter SHALL be loaded with the latched len.
REQ-022 RUN: b4_enable=1, b4_mode and b4_D SHALL equal the latched values, and the remaining count SHALL decrement each cycle.
REQ-023 RUN SHALL exit to DONE in the cycle after the remaining count is 0, so it lasts exactly len+1 cycles (len=0 gives 1 cycle; len=15 gives 16 cycles).
REQ-024 DONE SHALL last one cycle: b4_enable=0, done=1 and done_id=the owner; the FSM then returns to IDLE.
REQ-025 Requests raised while busy=1 SHALL NOT be acked; they are evaluated only in IDLE.
REQ-026 A request deasserted before its ack SHALL be withdrawn with no side effects.
REQ-027 Back-to-back: a request held through DONE SHALL be granted in the cycle after DONE, so there are 2 cycles between RUN periods.
REQ-028 Outside RUN, b4_enable SHALL be 0; b4_mode and b4_D SHALL hold their last values.

Reset
REQ-029 While b4_reset_n=0, the block SHALL asynchronously force:
- state=IDLE
- ack0=ack1=0
- b4_enable=0, b4_mode=00, b4_D=0
- busy=done=done_id=done_abort=0
- last-grant=1, remaining count=0
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse; after release, the FSM SHALL start in IDLE.

Configuration
REQ-031 Macro COUNTER_B4_CTRL_RCO_STOP_EN defined: in RUN with latched mode != 11, b4_rco=1 SHALL end RUN immediately and enter DONE with done_abort=1; in mode 11, b4_rco SHALL be ignored.
REQ-032 Macro undefined: b4_rco SHALL be ignored, done_abort SHALL be tied 0, and RUN length SHALL always be len+1.

Verification
REQ-033 Reset and idle: release b4_reset_n with no requests -> all outputs 0, busy=0, indefinitely.
REQ-034 Single request: req0 with mode=10, len=3, d=5 -> ack0 in the cycle after req0 rises; b4_enable=1 with b4_mode=10 for exactly 4 cycles; then done=1, done_id=0.
REQ-035 Tie and fairness: req0 and req1 both held, len=0 -> grants go 0, 1, 0, 1 with done_id matching; each RUN lasts 1 cycle.
REQ-036 Busy exclusion: req1 raised during req0's RUN (len=7) -> no ack1 until after done; ack1 arrives in the cycle after DONE.
REQ-037 Reset mid-RUN: assert b4_reset_n=0 in RUN cycle 2 of len=5 -> outputs go to reset values immediately; no done pulse.
REQ-038 RCO stop (macro defined): mode=00, len=15, b4_rco=1 in RUN cycle 4 -> DONE follows, done_abort=1; same stimulus with mode=11 -> full 16 cycles, done_abort=0.

Source files
------------

// File: rtl/counter_b4_ctrl.sv
// Two-requester round-robin controller that runs an external counter for len+1 cycles per request.
// Optional feature: define COUNTER_B4_CTRL_RCO_STOP_EN to end RUN early on b4_rco (ignored in mode 11).
module counter_b4_ctrl #(
    parameter int DW = 4,
    parameter int LW = 4
) (
    input  logic          b4_clk,
    input  logic          b4_reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    cmd0_mode,
    input  logic [1:0]    cmd1_mode,
    input  logic [LW-1:0] cmd0_len,
    input  logic [LW-1:0] cmd1_len,
    input  logic [DW-1:0] cmd0_d,
    input  logic [DW-1:0] cmd1_d,
    input  logic          b4_rco,
    output logic          ack0,
    output logic          ack1,
    output logic          b4_enable,
    output logic [1:0]    b4_mode,
    output logic [DW-1:0] b4_D,
    output logic          busy,
    output logic          done,
    output logic          done_id,
    output logic          done_abort,
    output logic [1:0]    dbg_state_o
);

    // Handshake: reqN is a level held with stable cmdN_* until ackN; ackN is a
    // one-cycle pulse in GRANT, and a req dropped before its ack is simply forgotten.
    typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          owner_q, owner_d;
    logic [1:0]    mode_l_q, mode_l_d;
    logic [LW-1:0] len_l_q, len_l_d;
    logic [DW-1:0] d_l_q, d_l_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic          en_q, en_d;
    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          done_id_q, done_id_d;
    logic          abort_q, abort_d;
    logic          rco_stop;
    logic          win;

`ifdef COUNTER_B4_CTRL_RCO_STOP_EN
    assign rco_stop = b4_rco && (mode_l_q != 2'b11);
`else
    logic unused_rco;
    assign unused_rco = b4_rco;
    assign rco_stop   = 1'b0;
`endif

    assign win = (req0 && req1) ? ~last_q : req1;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        mode_l_d = mode_l_q;
        len_l_d  = len_l_q;
        d_l_d    = d_l_q;
        rem_d    = rem_q;
        abort_d  = 1'b0;
        case (state_q)
            // Arbitration also runs while leaving DONE so a held request is
            // granted straight after completion.
            IDLE, DONE: begin
                if (req0 || req1) begin
                    state_d  = GRANT;
                    last_d   = win;
                    owner_d  = win;
                    mode_l_d = win ? cmd1_mode : cmd0_mode;
                    len_l_d  = win ? cmd1_len  : cmd0_len;
                    d_l_d    = win ? cmd1_d    : cmd0_d;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                rem_d   = len_l_q;
                state_d = RUN;
            end
            RUN: begin
                if (rco_stop) begin
                    state_d = DONE;
                    abort_d = 1'b1;
                end else if (rem_q == '0) begin
                    state_d = DONE;
                end else begin
                    rem_d = rem_q - LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        ack0_d    = (state_d == GRANT) && !owner_d;
        ack1_d    = (state_d == GRANT) && owner_d;
        en_d      = (state_d == RUN);
        mode_d    = (state_q == GRANT) ? mode_l_q : mode_q;
        dat_d     = (state_q == GRANT) ? d_l_q : dat_q;
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        done_id_d = done_d && owner_q;
    end

    always_ff @(posedge b4_clk or negedge b4_reset_n) begin
        if (!b4_reset_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            mode_l_q  <= 2'b00;
            len_l_q   <= '0;
            d_l_q     <= '0;
            rem_q     <= '0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            en_q      <= 1'b0;
            mode_q    <= 2'b00;
            dat_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            mode_l_q  <= mode_l_d;
            len_l_q   <= len_l_d;
            d_l_q     <= d_l_d;
            rem_q     <= rem_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            dat_q     <= dat_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            abort_q   <= abort_d;
        end
    end

    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign b4_enable   = en_q;
    assign b4_mode     = mode_q;
    assign b4_D        = dat_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign done_abort  = abort_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_counter_b4_ctrl.sv
// Bench for counter_b4_ctrl: directed scenarios plus random requesters, checked
// every cycle against an interval-based reference model of each operation.
module tb_counter_b4_ctrl;

    localparam int DW = 4;
    localparam int LW = 4;
`ifdef COUNTER_B4_CTRL_RCO_STOP_EN
    localparam bit RCO_STOP = 1'b1;
`else
    localparam bit RCO_STOP = 1'b0;
`endif

    logic          b4_clk;
    logic          b4_reset_n;
    logic          rq[2];
    logic [1:0]    md[2];
    logic [LW-1:0] ln[2];
    logic [DW-1:0] dd[2];
    logic          b4_rco;
    logic          ack0, ack1, b4_enable, busy, done, done_id, done_abort;
    logic [1:0]    b4_mode;
    logic [DW-1:0] b4_D;
    logic [1:0]    dbg_state;

    counter_b4_ctrl #(.DW(DW), .LW(LW)) dut (
        .b4_clk(b4_clk), .b4_reset_n(b4_reset_n),
        .req0(rq[0]), .req1(rq[1]),
        .cmd0_mode(md[0]), .cmd1_mode(md[1]),
        .cmd0_len(ln[0]), .cmd1_len(ln[1]),
        .cmd0_d(dd[0]), .cmd1_d(dd[1]),
        .b4_rco(b4_rco),
        .ack0(ack0), .ack1(ack1), .b4_enable(b4_enable),
        .b4_mode(b4_mode), .b4_D(b4_D), .busy(busy),
        .done(done), .done_id(done_id), .done_abort(done_abort),
        .dbg_state_o(dbg_state)
    );

    // clock / reset
    initial b4_clk = 1'b0;
    always #5 b4_clk = ~b4_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [0:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each operation is a set of cycle intervals measured from
    // its grant edge (ack at g, enable over [g+1, g+1+len], done at the next edge).
    int         m_e, m_g, m_rlo, m_rhi, m_done;
    bit         m_act, m_own, m_abort, m_last;
    logic [1:0] m_mode;
    logic [DW-1:0] m_d;
    logic       x_ack0, x_ack1, x_en, x_done, x_id, x_abort, x_busy;
    logic [1:0] x_mode;
    logic [DW-1:0] x_D;

    task automatic model_reset();
        m_act = 0; m_last = 1; m_abort = 0;
        x_ack0 = 0; x_ack1 = 0; x_en = 0; x_done = 0; x_id = 0; x_abort = 0; x_busy = 0;
        x_mode = 2'b00; x_D = '0;
    endtask

    task automatic model_edge();
        bit w;
        if (!b4_reset_n) begin
            model_reset();
            return;
        end
        m_e++;
        if (RCO_STOP && m_act && b4_rco && m_mode != 2'b11 &&
            (m_e - 1) >= m_rlo && (m_e - 1) <= m_rhi) begin
            m_rhi = m_e - 1; m_done = m_e; m_abort = 1;
        end
        if (!m_act || m_e > m_done) begin
            m_act = 0;
            if (rq[0] || rq[1]) begin
                w = (rq[0] && rq[1]) ? !m_last : rq[1];
                m_last = w; m_own = w; m_act = 1; m_abort = 0;
                m_mode = md[w]; m_d = dd[w];
                m_g = m_e; m_rlo = m_e + 1; m_rhi = m_e + 1 + int'(ln[w]); m_done = m_rhi + 1;
            end
        end
        x_ack0  = m_act && m_e == m_g && !m_own;
        x_ack1  = m_act && m_e == m_g && m_own;
        x_en    = m_act && m_e >= m_rlo && m_e <= m_rhi;
        if (x_en) begin
            x_mode = m_mode; x_D = m_d;
        end
        x_done  = m_act && m_e == m_done;
        x_id    = x_done && m_own;
        x_abort = x_done && m_abort;
        x_busy  = m_act;
    endtask

    task automatic check_outputs();
        check_eq("ack0", ack0, x_ack0);
        check_eq("ack1", ack1, x_ack1);
        check_eq("b4_enable", b4_enable, x_en);
        check_eq("b4_mode", b4_mode, x_mode);
        check_eq("b4_D", b4_D, x_D);
        check_eq("busy", busy, x_busy);
        check_eq("done", done, x_done);
        check_eq("done_id", done_id, x_id);
        check_eq("done_abort", done_abort, x_abort);
    endtask

    // driver tasks: inputs change only at the falling edge
    task automatic tick();
        model_edge();
        @(negedge b4_clk);
        check_outputs();
    endtask

    task automatic set_cmd(input int n, input logic [1:0] mo, input logic [LW-1:0] le, input logic [DW-1:0] da);
        rq[n] = 1'b1; md[n] = mo; ln[n] = le; dd[n] = da;
    endtask

    task automatic new_cmd(input int n);
        int sel;
        sel = $urandom_range(0, 3);
        md[n] = 2'($urandom_range(0, 3));
        ln[n] = (sel == 0) ? '0 : (sel == 1) ? '1 : LW'($urandom_range(0, 15));
        dd[n] = DW'($urandom);
    endtask

    task automatic agent(input int n);
        logic acked;
        acked = (n == 0) ? x_ack0 : x_ack1;
        if (rq[n] && acked) begin
            if ($urandom_range(0, 3) == 0) new_cmd(n);
            else rq[n] = 1'b0;
        end else if (rq[n]) begin
            if ($urandom_range(0, 19) == 0) rq[n] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            rq[n] = 1'b1;
            new_cmd(n);
        end
    endtask

    task automatic rco_run(input logic [1:0] mo, input int exp_en, input logic exp_ab);
        int en_cnt = 0;
        logic ab = 1'b0;
        set_cmd(0, mo, 4'd15, 4'd7);
        tick();
        rq[0] = 1'b0;
        for (int i = 0; i < 24; i++) begin
            b4_rco = (i == 4);
            tick();
            if (b4_enable) en_cnt++;
            if (done && done_abort) ab = 1'b1;
        end
        b4_rco = 1'b0;
        check_eq("rco_en_cycles", en_cnt, exp_en);
        check_eq("rco_abort_seen", ab, exp_ab);
    endtask

    initial begin
        int en_cnt, seen_done, t_done, t_ack;
        b4_reset_n = 1'b0;
        b4_rco = 1'b0;
        for (int n = 0; n < 2; n++) begin
            rq[n] = 1'b0; md[n] = '0; ln[n] = '0; dd[n] = '0;
        end
        m_e = 0;
        model_reset();
        repeat (3) @(negedge b4_clk);
        check_outputs();
        b4_reset_n = 1'b1;

        // idle after reset
        repeat (6) tick();

        // single request
        set_cmd(0, 2'b10, 4'd3, 4'd5);
        tick();
        check_eq("single_ack0", ack0, 1'b1);
        rq[0] = 1'b0;
        en_cnt = 0; seen_done = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (b4_enable) en_cnt++;
            if (done) begin
                seen_done++;
                check_eq("single_done_id", done_id, 1'b0);
            end
        end
        check_eq("single_en_cycles", en_cnt, 4);
        check_eq("single_done_count", seen_done, 1);

        // busy exclusion: req1 raised during req0's run
        set_cmd(0, 2'b01, 4'd7, 4'd9);
        tick();
        rq[0] = 1'b0;
        repeat (3) tick();
        set_cmd(1, 2'b11, 4'd2, 4'd3);
        t_done = -1; t_ack = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done && t_done < 0) t_done = i;
            if (ack1 && t_ack < 0) begin
                t_ack = i;
                rq[1] = 1'b0;
            end
        end
        check_eq("busy_excl_ack1", t_ack, t_done + 1);

        // tie and fairness, both held, len 0
        set_cmd(0, 2'b00, 4'd0, 4'd1);
        set_cmd(1, 2'b01, 4'd0, 4'd2);
        exp_q = {1'b0, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done && exp_q.size() > 0) check_eq("tie_order", done_id, exp_q.pop_front());
        end
        check_eq("tie_left", exp_q.size(), 0);
        rq[0] = 1'b0; rq[1] = 1'b0;
        repeat (3) tick();

        // reset in the second run cycle
        set_cmd(0, 2'b10, 4'd5, 4'd6);
        tick();
        rq[0] = 1'b0;
        repeat (2) tick();
        check_eq("rst_pre_enable", b4_enable, 1'b1);
        b4_reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) tick();
        b4_reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen_done++;
        end
        check_eq("rst_no_done", seen_done, 0);

        // rco stop (mode 00) and rco ignored (mode 11)
        rco_run(2'b00, RCO_STOP ? 4 : 16, RCO_STOP);
        rco_run(2'b11, 16, 1'b0);

        // random requesters
        for (int c = 0; c < 1500; c++) begin
            agent(0);
            agent(1);
            b4_rco = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 199) == 0) b4_reset_n = 1'b0;
            tick();
            b4_reset_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
